// File: rtl/ps2_keystroke_decoder_pkg.sv
// Shared typing-game definitions: keystroke codes, PS/2 set-2 prefixes, FSM state types
// and the scan-code to keystroke mapping.
package typing_pkg;

    localparam logic [4:0] KEY_A         = 5'd0;
    localparam logic [4:0] KEY_Z         = 5'd25;
    localparam logic [4:0] KEY_SPACE     = 5'd26;
    localparam logic [4:0] KEY_BACKSPACE = 5'd27;
    localparam logic [4:0] KEY_ENTER     = 5'd28;
    localparam logic [4:0] KEY_NONE      = 5'd31;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {FR_IDLE, FR_DATA, FR_PARITY, FR_STOP} frame_st_t;
    typedef enum logic [1:0] {SQ_MAKE, SQ_BRK, SQ_EXT, SQ_EXT_BRK} seq_st_t;

    function automatic logic [4:0] scan_to_key(input logic [7:0] sc);
        logic [4:0] k;
        k = KEY_NONE;
        case (sc)
            8'h1C: k = 5'd0;   8'h32: k = 5'd1;   8'h21: k = 5'd2;   8'h23: k = 5'd3;
            8'h24: k = 5'd4;   8'h2B: k = 5'd5;   8'h34: k = 5'd6;   8'h33: k = 5'd7;
            8'h43: k = 5'd8;   8'h3B: k = 5'd9;   8'h42: k = 5'd10;  8'h4B: k = 5'd11;
            8'h3A: k = 5'd12;  8'h31: k = 5'd13;  8'h44: k = 5'd14;  8'h4D: k = 5'd15;
            8'h15: k = 5'd16;  8'h2D: k = 5'd17;  8'h1B: k = 5'd18;  8'h2C: k = 5'd19;
            8'h3C: k = 5'd20;  8'h2A: k = 5'd21;  8'h1D: k = 5'd22;  8'h22: k = 5'd23;
            8'h35: k = 5'd24;  8'h1A: k = KEY_Z;
            8'h29: k = KEY_SPACE;
            8'h66: k = KEY_BACKSPACE;
            8'h5A: k = KEY_ENTER;
            default: k = KEY_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_keystroke_decoder_if.sv
// Keystroke link between the PS/2 decoder (master) and PlayerActivity (slave).
interface ps2_keystroke_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [4:0] keystroke;
    logic       key_press;
    logic       keyReleased;
    logic       frame_err;

    modport master (input ps2_clk, ps2_data, output keystroke, key_press, keyReleased, frame_err);
    modport slave  (output ps2_clk, ps2_data, input keystroke, key_press, keyReleased, frame_err);
endinterface

// File: rtl/ps2_keystroke_decoder_frame_rx.sv
// PS/2 frame receiver: sync + glitch filter on ps2_clk, 11-bit frame check, inter-edge timeout.
// byte_valid/frame_err are 1-cycle pulses the cycle after the stop-bit fall; no backpressure.
module ps2_frame_rx
    import typing_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int TIMEOUT_US = 200,
    parameter int FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] data_byte,
    output logic       frame_err
);
    localparam int TMO_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;
    localparam int TW      = $clog2(TMO_CYC + 1);
    localparam int FW      = $clog2(FILTER_LEN + 1);

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt, fall;
    logic [FW-1:0] flt_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    bit_cnt;
    logic          par_ok;
    logic          bv_nxt, err_nxt, tmo_exp;
    frame_st_t     state, state_nxt;

    always_comb begin
        state_nxt = state;
        bv_nxt    = 1'b0;
        err_nxt   = 1'b0;
        tmo_exp   = (state != FR_IDLE) && (tmo_cnt == TW'(TMO_CYC - 1));
        if (fall) begin
            case (state)
                FR_IDLE:   if (!dat_s2) state_nxt = FR_DATA;
                FR_DATA:   if (bit_cnt == 3'd7) state_nxt = FR_PARITY;
                FR_PARITY: state_nxt = FR_STOP;
                FR_STOP: begin
                    state_nxt = FR_IDLE;
                    bv_nxt    = dat_s2 && par_ok;
                    err_nxt   = !(dat_s2 && par_ok);
                end
                default:   state_nxt = FR_IDLE;
            endcase
        end else if (tmo_exp) begin
            // an edge arriving in the expiry cycle wins, hence the else
            state_nxt = FR_IDLE;
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            filt       <= 1'b1;
            flt_cnt    <= '0;
            fall       <= 1'b0;
            state      <= FR_IDLE;
            tmo_cnt    <= '0;
            bit_cnt    <= '0;
            data_byte  <= '0;
            par_ok     <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;

            fall <= filt && !clk_s2 && (flt_cnt == FW'(FILTER_LEN - 1));
            if (clk_s2 == filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                filt    <= clk_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end

            state      <= state_nxt;
            byte_valid <= bv_nxt;
            frame_err  <= err_nxt;

            if (fall || state == FR_IDLE) tmo_cnt <= '0;
            else                          tmo_cnt <= tmo_cnt + TW'(1);

            if (fall) begin
                case (state)
                    FR_IDLE:   bit_cnt <= '0;
                    FR_DATA: begin
                        data_byte <= {dat_s2, data_byte[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                    end
                    FR_PARITY: par_ok <= ^{dat_s2, data_byte};
                    default:   ;
                endcase
            end
        end
    end
endmodule

// File: rtl/ps2_keystroke_decoder.sv
// PS/2 set-2 make/break decoder to 5-bit keystroke with press/release strobes, 2 cycles after stop fall.
// Define PS2_TYPEMATIC_EN to let repeated makes of the held key strobe key_press; no backpressure.
module ps2_keystroke_decoder
    import typing_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int TIMEOUT_US = 200,
    parameter int FILTER_LEN = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    ps2_keystroke_decoder_if.master    bus
);
    logic       byte_valid, rx_err;
    logic [7:0] rx_byte;
    logic [4:0] code, held_code, keystroke;
    logic       is_make, is_break, rpt_ok, press_nxt, rel_nxt, key_press, key_rel;
    seq_st_t    seq, seq_nxt;

    ps2_frame_rx #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US), .FILTER_LEN(FILTER_LEN)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (bus.ps2_clk),
        .ps2_data   (bus.ps2_data),
        .byte_valid (byte_valid),
        .data_byte  (rx_byte),
        .frame_err  (rx_err)
    );

    assign code = scan_to_key(rx_byte);

`ifdef PS2_TYPEMATIC_EN
    assign rpt_ok = 1'b1;
`else
    assign rpt_ok = (code != held_code);
`endif

    always_comb begin
        seq_nxt  = seq;
        is_make  = 1'b0;
        is_break = 1'b0;
        if (byte_valid) begin
            case (seq)
                SQ_MAKE: begin
                    if (rx_byte == SC_BREAK)    seq_nxt = SQ_BRK;
                    else if (rx_byte == SC_EXT) seq_nxt = SQ_EXT;
                    else                        is_make = 1'b1;
                end
                SQ_BRK: begin
                    is_break = 1'b1;
                    seq_nxt  = SQ_MAKE;
                end
                SQ_EXT:  seq_nxt = (rx_byte == SC_BREAK) ? SQ_EXT_BRK : SQ_MAKE;
                default: seq_nxt = SQ_MAKE;
            endcase
        end
        press_nxt = is_make && (code != KEY_NONE) && rpt_ok;
        rel_nxt   = is_break && (code != KEY_NONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq       <= SQ_MAKE;
            keystroke <= KEY_NONE;
            held_code <= KEY_NONE;
            key_press <= 1'b0;
            key_rel   <= 1'b0;
        end else begin
            seq       <= seq_nxt;
            key_press <= press_nxt;
            key_rel   <= rel_nxt;
            if (press_nxt || rel_nxt) keystroke <= code;
            if (press_nxt)                          held_code <= code;
            else if (rel_nxt && code == held_code) held_code <= KEY_NONE;
        end
    end

    assign bus.keystroke   = keystroke;
    assign bus.key_press   = key_press;
    assign bus.keyReleased = key_rel;
    assign bus.frame_err   = rx_err;
endmodule
